// File: rtl/brightness_stream_ctrl_if.sv
// Pixel stream bundle for brightness_stream_ctrl.
// Source side: s_valid/s_ready/s_pixel (pixel in, from file/DMA reader).
// Sink side:   m_valid/m_ready/m_pixel/m_sof/m_eol (processed pixel out).
// master: the controller's view; slave: the environment (source + sink).
interface brightness_stream_ctrl_if #(
  parameter int unsigned PW = 24
);
  logic          s_valid;
  logic          s_ready;
  logic [PW-1:0] s_pixel;
  logic          m_valid;
  logic          m_ready;
  logic [PW-1:0] m_pixel;
  logic          m_sof;
  logic          m_eol;

  modport master (
    input  s_valid, s_pixel, m_ready,
    output s_ready, m_valid, m_pixel, m_sof, m_eol
  );

  modport slave (
    output s_valid, s_pixel, m_ready,
    input  s_ready, m_valid, m_pixel, m_sof, m_eol
  );
endinterface

// File: rtl/brightness_stream_ctrl.sv
// Frame sequencer around the combinational brightness datapath.
// Captures source pixels into stage 1 (drives dp_*_in), samples the datapath
// results into stage 2 (drives m_pixel), counts pixels against W*H and tags
// first-of-frame / end-of-line on the output side.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               one-cycle frame start request (honoured in IDLE only)
//   frame_w, frame_h    frame size, sampled on accepted start
//   bus                 source/sink pixel stream (master modport)
//   dp_{r,g,b}_in       datapath inputs from stage-1 register
//   dp_{r,g,b}_out      datapath results (combinational)
//   busy                frame in progress
//   done                one-cycle pulse on frame completion
module brightness_stream_ctrl #(
  parameter int unsigned CW = 12,
  parameter int unsigned PW = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [CW-1:0]             frame_w,
  input  logic [CW-1:0]             frame_h,
  brightness_stream_ctrl_if.master  bus,
  output logic [7:0]                dp_r_in,
  output logic [7:0]                dp_g_in,
  output logic [7:0]                dp_b_in,
  input  logic [7:0]                dp_r_out,
  input  logic [7:0]                dp_g_out,
  input  logic [7:0]                dp_b_out,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CW-1:0]   ONE_C  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [2*CW-1:0] ONE_IN = {{(2*CW-1){1'b0}}, 1'b1};

  state_t          state;
  logic [CW-1:0]   w_q;
  logic [CW-1:0]   h_q;
  logic [CW-1:0]   col;
  logic [CW-1:0]   row;
  logic [2*CW-1:0] in_cnt;
  logic [2*CW-1:0] total;
  logic [PW-1:0]   s1;
  logic [PW-1:0]   s2;
  logic            s1_valid;
  logic            s2_valid;
  logic            s1_adv;
  logic            accept;
  logic            out_hs;
  logic            last_in;
  logic            last_col;
  logic            last_row;

  always_comb begin
    s1_adv      = s1_valid && (!s2_valid || bus.m_ready);
    bus.s_ready = (state == RUN) && (!s1_valid || s1_adv);
    accept      = bus.s_valid && bus.s_ready;
    out_hs      = s2_valid && bus.m_ready;
    total       = {{CW{1'b0}}, w_q} * {{CW{1'b0}}, h_q};
    last_in     = ((in_cnt + ONE_IN) == total);
    last_col    = (col == (w_q - ONE_C));
    last_row    = (row == (h_q - ONE_C));
    // Tags come from the output-side counters so they stay aligned with s2.
    bus.m_valid = s2_valid;
    bus.m_pixel = s2;
    bus.m_sof   = s2_valid && (col == '0) && (row == '0);
    bus.m_eol   = s2_valid && last_col;
    dp_r_in     = s1[23:16];
    dp_g_in     = s1[15:8];
    dp_b_in     = s1[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      w_q      <= '0;
      h_q      <= '0;
      col      <= '0;
      row      <= '0;
      in_cnt   <= '0;
      s1       <= '0;
      s2       <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;

      if (accept) begin
        s1       <= bus.s_pixel;
        s1_valid <= 1'b1;
        in_cnt   <= in_cnt + ONE_IN;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s1_adv) begin
        s2       <= {dp_r_out, dp_g_out, dp_b_out};
        s2_valid <= 1'b1;
      end else if (bus.m_ready) begin
        s2_valid <= 1'b0;
      end

      if (out_hs) begin
        if (last_col) begin
          col <= '0;
          row <= row + ONE_C;
        end else begin
          col <= col + ONE_C;
        end
      end

      case (state)
        IDLE: begin
          if (start && (frame_w != '0) && (frame_h != '0)) begin
            w_q    <= frame_w;
            h_q    <= frame_h;
            col    <= '0;
            row    <= '0;
            in_cnt <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (accept && last_in) state <= DRAIN;
        end
        DRAIN: begin
          if (out_hs && last_col && last_row) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
